// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone classic-cycle register-memory slave.
package wb_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_slv_state_e;

  typedef struct packed {
    logic [WB_AW-1:0]   addr;
    logic [WB_DW-1:0]   data;
    logic [WB_SELW-1:0] sel;
    logic               we;
  } wb_req_t;

  typedef enum logic [1:0] {
    OK,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_SEL
  } wb_dec_e;

  // Expand byte-lane enables into a full-width bit mask.
  function automatic logic [WB_DW-1:0] sel_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] mask;
    for (int i = 0; i < WB_SELW; i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B3 classic bus bundle between a master driver and the memory slave.
interface wb_slave_mem_if
  import wb_pkg::*;
;

  logic [WB_DW-1:0]   wb_data_i;
  logic [WB_DW-1:0]   wb_data_o;
  logic [WB_AW-1:0]   wb_addr_i;
  logic [WB_SELW-1:0] wb_sel_i;
  logic               wb_we_i;
  logic               wb_cyc_i;
  logic               wb_stb_i;
  logic               wb_ack_o;
  logic               wb_err_o;

  modport slave (
    input  wb_data_i, wb_addr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_data_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_data_i, wb_addr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_data_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wb_slave_mem_array.sv
// Word-addressed register array: sync clear, byte-enable write port, async read port.
module wb_slave_mem_array
  import wb_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IW-1:0]      waddr,
  input  logic [WB_SELW-1:0] wsel,
  input  logic [WB_DW-1:0]   wdata,
  input  logic [IW-1:0]      raddr,
  output logic [WB_DW-1:0]   rdata
);

  logic [WB_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < WB_SELW; b++) begin
        if (wsel[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 classic slave with programmable wait states over a byte-writable register memory.
// One transfer outstanding; ack/err is a registered single-cycle pulse.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_slave_mem_if.slave  wb
);

  localparam int          IW   = $clog2(MEM_DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * MEM_DEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  function automatic wb_dec_e decode(input logic [WB_AW-1:0] addr,
                                     input logic [WB_SELW-1:0] sel);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    if (off[32] || (off >= SPAN)) return ERR_RANGE;
    if (addr[1:0] != 2'b00)       return ERR_ALIGN;
    if (sel == '0)                return ERR_SEL;
    return OK;
  endfunction

  function automatic logic [IW-1:0] word_index(input logic [WB_AW-1:0] addr);
    return IW'((addr - BASE_ADDR) >> 2);
  endfunction

  wb_slv_state_e    state;
  wb_req_t          req;
  wb_dec_e          dec;
  logic [3:0]       cnt;
  logic             ack;
  logic             err;
  logic [WB_DW-1:0] data_out;

  wb_req_t          live;
  logic             req_valid;
  logic             enter_resp_idle;
  logic             enter_resp_wait;
  wb_req_t          cmt_req;
  wb_dec_e          cmt_dec;
  logic             mem_we;
  logic [WB_DW-1:0] rdata;

  assign live = '{addr: wb.wb_addr_i, data: wb.wb_data_i, sel: wb.wb_sel_i, we: wb.wb_we_i};
  assign req_valid = wb.wb_cyc_i & wb.wb_stb_i;

  // Write commits on the edge entering RESP; with zero wait states that is the sample edge itself.
  assign enter_resp_idle = (state == IDLE) && req_valid && (WAIT_STATES == 0);
  assign enter_resp_wait = (state == WAIT) && req_valid && (cnt == 4'd1);
  assign cmt_req = enter_resp_idle ? live : req;
  assign cmt_dec = enter_resp_idle ? decode(live.addr, live.sel) : dec;
  assign mem_we  = (enter_resp_idle || enter_resp_wait) && cmt_req.we && (cmt_dec == OK);

  wb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (mem_we),
    .waddr (word_index(cmt_req.addr)),
    .wsel  (cmt_req.sel),
    .wdata (cmt_req.data),
    .raddr (word_index(req.addr)),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      req      <= '0;
      dec      <= OK;
      cnt      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      ack      <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req   <= live;
            dec   <= decode(live.addr, live.sel);
            cnt   <= WS;
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req_valid) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          if (dec == OK) begin
            ack <= 1'b1;
            if (!req.we) data_out <= rdata & sel_mask(req.sel);
          end else begin
            err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o  = ack;
  assign wb.wb_err_o  = err;
  assign wb.wb_data_o = data_out;

endmodule
